// File: rtl/register_file_pkg.sv
// Shared types and helpers for the register file: clear-sweep FSM states and
// the per-index reset value used by reset, shadow init and the clear sweep.
package regfile_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // Register 0 and 1 have programmable reset values; every other entry resets to zero.
    function automatic int reset_value(input int idx, input int rv0, input int rv1);
        int val;
        case (idx)
            0:       val = rv0;
            1:       val = rv1;
            default: val = 0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/register_file_if.sv
// Bus bundle between the datapath and the register file: write port, two read
// ports, shadow snapshot/restore controls and the clear sweep handshake.
interface register_file_if #(
    parameter int N  = 16,
    parameter int AW = 2
);
    logic          w;
    logic [AW-1:0] wsel;
    logic [N-1:0]  s;
    logic [AW-1:0] rsel_a;
    logic [AW-1:0] rsel_b;
    logic [N-1:0]  ra;
    logic [N-1:0]  rb;
    logic          snap;
    logic          rest;
    logic          clr;
    logic          busy;

    modport master (
        output w, wsel, s, rsel_a, rsel_b, snap, rest, clr,
        input  ra, rb, busy
    );

    modport slave (
        input  w, wsel, s, rsel_a, rsel_b, snap, rest, clr,
        output ra, rb, busy
    );
endinterface

// File: rtl/register_file_clr_seq.sv
// Clear sequencer: walks an index 0..DEPTH-1, one entry per cycle, after a clr
// pulse in IDLE. busy/clr_active are flop outputs that are high during the walk.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic          clr_active,
    output logic [AW-1:0] clr_idx,
    output logic          busy
);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d;

    // Next-state and index logic; the last swept index returns the FSM to IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    idx_d   = {AW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                    idx_d   = {AW{1'b0}};
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = {AW{1'b0}};
            end
        endcase
        busy_d = (state_d == CLEAR);
    end

    // State, index and busy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= {AW{1'b0}};
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    assign clr_active = busy_q;
    assign clr_idx    = idx_q;
    assign busy       = busy_q;

endmodule

// File: rtl/register_file.sv
// DEPTH x N register file: one write port, two registered write-through read
// ports, single-cycle whole-file shadow snapshot/restore and a sequenced clear.
module register_file
    import regfile_pkg::*;
#(
    parameter int N     = 16,
    parameter int DEPTH = 4,
    parameter int RV0   = 2,
    parameter int RV1   = 1
) (
    input  logic            clk,
    input  logic            rst,
    register_file_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    logic [N-1:0]  reg_q    [DEPTH];
    logic [N-1:0]  reg_d    [DEPTH];
    logic [N-1:0]  shadow_q [DEPTH];
    logic [N-1:0]  shadow_d [DEPTH];
    logic [N-1:0]  ra_q, ra_d;
    logic [N-1:0]  rb_q, rb_d;
    logic          clr_active_s;
    logic [AW-1:0] clr_idx_s;
    logic          busy_s;

    regfile_clr_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_seq (
        .clk        (clk),
        .rst        (rst),
        .clr        (bus.clr),
        .clr_active (clr_active_s),
        .clr_idx    (clr_idx_s),
        .busy       (busy_s)
    );

    // File/shadow update with sweep > rest > snap > w; reads see the post-update file.
    always_comb begin
        reg_d    = reg_q;
        shadow_d = shadow_q;
        if (clr_active_s) begin
            reg_d[clr_idx_s] = N'(reset_value(32'(clr_idx_s), RV0, RV1));
        end else if (bus.rest) begin
            reg_d = shadow_q;
        end else begin
            // Snapshot captures the pre-edge file, so a same-cycle write is not in the shadow.
            if (bus.snap) begin
                shadow_d = reg_q;
            end else begin
                shadow_d = shadow_q;
            end
            if (bus.w) begin
                reg_d[bus.wsel] = bus.s;
            end else begin
                reg_d[bus.wsel] = reg_q[bus.wsel];
            end
        end
        ra_d = reg_d[bus.rsel_a];
        rb_d = reg_d[bus.rsel_b];
    end

    // Storage, shadow bank and read-data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]    <= N'(reset_value(i, RV0, RV1));
                shadow_q[i] <= N'(reset_value(i, RV0, RV1));
            end
            ra_q <= {N{1'b0}};
            rb_q <= {N{1'b0}};
        end else begin
            reg_q    <= reg_d;
            shadow_q <= shadow_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
        end
    end

    assign bus.ra   = ra_q;
    assign bus.rb   = rb_q;
    assign bus.busy = busy_s;

endmodule
